// File: rtl/calc_pkg.sv
// calc_pkg: shared opcodes, FSM state type and data width for the calculator
package calc_pkg;
  localparam int DW = 8;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
    OP_AND, OP_OR, OP_XOR, OP_NXOR, OP_NAND, OP_NOR
  } op_e;
  localparam logic [3:0] OP_LAST = 4'hB;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational 8-bit ALU, flags = {div_by_zero, negative, carry, zero}
module calc_alu
  import calc_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    sel,
  output logic [DW-1:0] dout,
  output logic [3:0]    flags
);
  logic [DW:0] wide;
  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  always_comb begin
    wide = '0;
    case (sel)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_MUL:  wide = {|prod[2*DW-1:DW], prod[DW-1:0]};
      OP_DIV:  wide = (b == '0) ? {1'b0, {DW{1'b1}}} : {1'b0, a / b};
      OP_SHL:  wide = {1'b0, a << b[2:0]};
      OP_SHR:  wide = {1'b0, a >> b[2:0]};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NXOR: wide = {1'b0, ~(a ^ b)};
      OP_NAND: wide = {1'b0, ~(a & b)};
      OP_NOR:  wide = {1'b0, ~(a | b)};
      default: wide = '0;
    endcase
  end
  assign dout  = wide[DW-1:0];
  assign flags = {sel == OP_DIV && b == '0, wide[DW-1], wide[DW], wide[DW-1:0] == '0};
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: command/response controller around the ALU with accumulator and op counter
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DW-1:0]    cmd_a,
  input  logic [DW-1:0]    cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic [3:0]       res_flags,
  output logic             res_err,
  output logic [DW-1:0]    acc,
  output logic [CNT_W-1:0] op_count
);
  state_e state, state_n;
  logic [DW-1:0] opa, opb, alu_dout;
  logic [3:0] op, alu_flags;
  logic illegal;
  assign illegal = op > OP_LAST;
  calc_alu u_alu (.a(opa), .b(opb), .sel(op), .dout(alu_dout), .flags(alu_flags));
  always_comb begin
    cmd_ready = state == IDLE;
    res_valid = state == RESP;
    state_n = (cmd_ready && cmd_valid) ? EXEC :
              (state == EXEC)          ? RESP :
              (res_valid && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      op        <= '0;
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      state <= state_n;
      if (cmd_ready && cmd_valid) begin
        opa <= cmd_use_acc ? acc : cmd_a;
        opb <= cmd_b;
        op  <= cmd_op;
      end
      if (state == EXEC) begin
        res_data  <= illegal ? '0 : alu_dout;
        res_flags <= illegal ? '0 : alu_flags;
        res_err   <= illegal;
      end
      // a legal capture overrides a coincident clear
      if (state == EXEC && !illegal) acc <= alu_dout;
      else if (acc_clr) acc <= '0;
      if (res_valid && res_ready && op_count != '1) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule
